// File: rtl/ks_sum_stage.sv
// Kogge-Stone adder output stage: forms sum/cout/ovf from the prefix-tree
// group vectors and delivers them through a 2-entry valid/ready buffer.
module ks_sum_stage #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] grp_g,
   input  logic [WIDTH-1:0] grp_p,
   input  logic [WIDTH-1:0] bit_p,
   input  logic             cin,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [TAG_W-1:0] out_tag
);

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             co;
      logic             ov;
      logic [TAG_W-1:0] tag;
   } entry_t;

   logic [WIDTH:0] carry;
   entry_t         new_entry;
   entry_t         head_entry;

   entry_t         buf_q [2];
   logic [1:0]     count_q, count_d;
   logic           head_q, head_d;
   logic           tail_q, tail_d;
   logic           accept, pop;

   // Carry into bit i is the group generate of bits below it, or cin
   // propagated through the whole group.
   // NOTE: every signal written in an always_comb gets a value on every path
   // (default first), otherwise synthesis infers a latch.
   always_comb begin
      carry            = '0;
      carry[0]         = cin;
      carry[WIDTH:1]   = grp_g | (grp_p & {WIDTH{cin}});
      new_entry        = '0;
      new_entry.res    = bit_p ^ carry[WIDTH-1:0];
      new_entry.co     = carry[WIDTH];
      new_entry.ov     = carry[WIDTH] ^ carry[WIDTH-1];
      new_entry.tag    = in_tag;
   end

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (accept) tail_d = ~tail_q;
      if (pop)    head_d = ~head_q;
      unique case ({accept, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples its inputs from before the edge, independent of order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   // NOTE: the entry storage is reset as well because the outputs read it
   // directly and must show zero after reset, not leftover data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q[0] <= '0;
         buf_q[1] <= '0;
      end else if (accept) begin
         buf_q[tail_q] <= new_entry;
      end
   end

   assign head_entry = buf_q[head_q];
   assign sum        = head_entry.res;
   assign cout       = head_entry.co;
   assign ovf        = head_entry.ov;
   assign out_tag    = head_entry.tag;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n && accept) begin
         assert ((grp_g & grp_p) == '0)
            else $error("group generate and propagate overlap on accepted beat");
         assert (bit_p[0] == grp_p[0])
            else $error("bit_p[0] differs from grp_p[0] on accepted beat");
      end
      if (rst_n) begin
         assert (count_q <= 2'd2)
            else $error("buffer count exceeds 2");
      end
   end
`endif

endmodule

// File: tb/tb_ks_sum_stage.sv
// Self-checking bench for ks_sum_stage (WIDTH=8): table vectors, random
// streaming, back-pressure, full-buffer and mid-operation reset sequences.
module tb_ks_sum_stage;

   localparam int W  = 8;
   localparam int TW = 4;

   logic          clk, rst_n;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  grp_g, grp_p, bit_p, sum;
   logic          cin, cout, ovf;
   logic [TW-1:0] in_tag, out_tag;

   ks_sum_stage #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .grp_g(grp_g), .grp_p(grp_p), .bit_p(bit_p), .cin(cin), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .out_tag(out_tag)
   );

   typedef struct packed {
      logic [W-1:0]  s;
      logic          co;
      logic          ov;
      logic [TW-1:0] tag;
   } exp_t;

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic          c;
      logic [TW-1:0] tag;
      logic [W-1:0]  s;
      logic          co;
      logic          ov;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_push = 0;
   int   n_pop = 0;
   int   cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input logic [TW-1:0] t);
      exp_t        e;
      logic [W:0]  full;
      full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      e.s   = full[W-1:0];
      e.co  = full[W];
      e.ov  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      e.tag = t;
      return e;
   endfunction

   // Builds the prefix-tree outputs the stage expects from raw operands.
   task automatic set_inputs(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input logic [TW-1:0] t);
      logic [W-1:0] g, p, gg, pp;
      g = a & b;
      p = a ^ b;
      gg[0] = g[0];
      pp[0] = p[0];
      for (int i = 1; i < W; i++) begin
         gg[i] = g[i] | (p[i] & gg[i-1]);
         pp[i] = p[i] & pp[i-1];
      end
      grp_g  = gg;
      grp_p  = pp;
      bit_p  = p;
      cin    = c;
      in_tag = t;
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [TW-1:0] t, input exp_t e);
      set_inputs(a, b, c, t);
      in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            sb.push_back(e);
            n_push++;
            #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      check("drive_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'(out_tag), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", 32'({sum, cout, ovf, out_tag}), 32'(e));
         end
         n_pop++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   vec_t tbl [7];
   exp_t e1, e3;
   int   t0, pops0;

   initial begin
      tbl[0] = '{8'h7F, 8'h01, 1'b0, 4'd3,  8'h80, 1'b0, 1'b1};
      tbl[1] = '{8'hFF, 8'h00, 1'b1, 4'd5,  8'h00, 1'b1, 1'b0};
      tbl[2] = '{8'h80, 8'h80, 1'b0, 4'd6,  8'h00, 1'b1, 1'b1};
      tbl[3] = '{8'h00, 8'h00, 1'b0, 4'd7,  8'h00, 1'b0, 1'b0};
      tbl[4] = '{8'h7F, 8'h00, 1'b1, 4'd8,  8'h80, 1'b0, 1'b1};
      tbl[5] = '{8'hFF, 8'hFF, 1'b1, 4'd9,  8'hFF, 1'b1, 1'b0};
      tbl[6] = '{8'h55, 8'hAA, 1'b0, 4'd10, 8'hFF, 1'b0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      set_inputs('0, '0, 1'b0, '0);
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_outputs",   32'({sum, cout, ovf, out_tag}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("first_edge_in_ready", 32'(in_ready), 32'd1);

      // Table vectors, back-to-back; first one also checks 1-cycle latency.
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].tag,
               '{tbl[i].s, tbl[i].co, tbl[i].ov, tbl[i].tag});
         if (i == 0) begin
            check("latency_valid", 32'(out_valid), 32'd1);
            check("latency_tag",   32'(out_tag),   32'd3);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      check("table_drained", 32'(sb.size()), 32'd0);

      // Random streaming at full rate.
      t0 = cyc;
      pops0 = n_pop;
      for (int i = 0; i < 16; i++) begin
         logic [W-1:0]  a, b;
         logic          c;
         logic [TW-1:0] t;
         a = W'($urandom_range(0, 255));
         b = W'($urandom_range(0, 255));
         c = 1'($urandom_range(0, 1));
         t = TW'(i);
         drive(a, b, c, t, model(a, b, c, t));
      end
      check("stream_cycles", 32'(cyc - t0), 32'd16);
      @(posedge clk); #1;
      check("stream_outputs", 32'(n_pop - pops0), 32'd16);
      check("stream_drained", 32'(sb.size()), 32'd0);

      // Back-pressure: fill both entries, hold a third beat upstream.
      out_ready = 1'b0;
      e1 = model(8'h12, 8'h34, 1'b0, 4'd1);
      drive(8'h12, 8'h34, 1'b0, 4'd1, e1);
      drive(8'hF0, 8'h0F, 1'b1, 4'd2, model(8'hF0, 8'h0F, 1'b1, 4'd2));
      e3 = model(8'hC3, 8'h4D, 1'b1, 4'd3);
      set_inputs(8'hC3, 8'h4D, 1'b1, 4'd3);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_hold", 32'({out_valid, sum, cout, ovf, out_tag}),
               32'({1'b1, e1}));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("full_no_accept", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("full_pop_in_ready", 32'(in_ready),  32'd1);
      check("full_pop_head",     32'(out_tag),   32'd2);
      @(posedge clk);
      sb.push_back(e3);
      n_push++;
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("accept_pop_valid", 32'(out_valid), 32'd1);
      check("accept_pop_head",  32'(out_tag),   32'd3);
      check("accept_pop_ready", 32'(in_ready),  32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_empty", 32'(out_valid), 32'd0);
      check("bp_drained", 32'(sb.size()), 32'd0);

      // Asynchronous reset with two beats buffered.
      @(posedge clk); #1;
      out_ready = 1'b0;
      drive(8'h01, 8'h02, 1'b0, 4'd11, model(8'h01, 8'h02, 1'b0, 4'd11));
      drive(8'h03, 8'h04, 1'b0, 4'd12, model(8'h03, 8'h04, 1'b0, 4'd12));
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid",   32'(out_valid), 32'd0);
      check("mid_rst_ready",   32'(in_ready),  32'd1);
      check("mid_rst_outputs", 32'({sum, cout, ovf, out_tag}), 32'd0);
      sb.delete();
      n_push -= 2;
      @(posedge clk); #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_rst_ready", 32'(in_ready),  32'd1);
         check("post_rst_stale", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
      drive(tbl[0].a, tbl[0].b, tbl[0].c, 4'd13,
            '{tbl[0].s, tbl[0].co, tbl[0].ov, 4'd13});
      repeat (2) @(posedge clk);
      #1;
      check("final_drained", 32'(sb.size()), 32'd0);
      check("push_pop_balance", 32'(n_pop), 32'(n_push));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
